winv_twiddle_sched: RTL and testbench

// - Read sequencer for one PE's inverse-NTT twiddle ROM (WINV storage, 1-cycle registered read).
// - Walks all RING_DEPTH INTT stages and drives the ROM read address for every butterfly slot.
// - Emits a valid flag and stage/slot tags aligned with the ROM data output.
// - One instance per PE, next to the PE butterfly, started by the top-level INTT controller.

---
 rtl/winv_twiddle_sched_pkg.sv | 27 ++
 rtl/winv_addr_calc.sv | 33 +++
 rtl/winv_twiddle_sched.sv | 152 +++++++++++++++
 tb/tb_winv_twiddle_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/winv_twiddle_sched_pkg.sv
// Shared types and helpers for the inverse-NTT twiddle read sequencer.
// Default ring/PE depths come from the project-wide defines.
`ifndef RING_DEPTH
`define RING_DEPTH 10
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 5
`endif

package winv_twiddle_sched_pkg;

  localparam int RING_DEPTH_DEF = `RING_DEPTH;
  localparam int PE_DEPTH_DEF   = `PE_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // First ROM word of per-PE stage k: the shared-twiddle stages occupy 0..pe_depth-1.
  function automatic int stage_base(input int pe_depth, input int k);
    return pe_depth + (32'sd1 <<< k) - 32'sd1;
  endfunction

endpackage

// File: rtl/winv_addr_calc.sv
// Combinational map from (stage, butterfly slot) to the WINV ROM read address.
module winv_addr_calc
  import winv_twiddle_sched_pkg::*;
#(
  parameter int RING_DEPTH = RING_DEPTH_DEF,
  parameter int PE_DEPTH   = PE_DEPTH_DEF,
  parameter int HLEN       = 9,
  parameter int STW        = 4,
  parameter int SW         = 4
) (
  input  logic [STW-1:0]  stage,
  input  logic [SW-1:0]   cnt,
  output logic [HLEN-1:0] raddr
);

  int k_s;
  int off_s;

  // Early stages share one twiddle; later stages step through 2^k words per stage.
  always_comb begin
    k_s   = 0;
    off_s = 0;
    raddr = '0;
    if (int'(stage) < PE_DEPTH) begin
      raddr = HLEN'(stage);
    end else begin
      k_s   = int'(stage) - PE_DEPTH;
      off_s = int'(cnt) >> (RING_DEPTH - PE_DEPTH - 1 - k_s);
      raddr = HLEN'(stage_base(PE_DEPTH, k_s) + off_s);
    end
  end

endmodule

// File: rtl/winv_twiddle_sched.sv
// Per-PE inverse-NTT twiddle ROM read sequencer: walks every stage and slot,
// drives the registered ROM address and emits valid/tag flags aligned with ROM data.
module winv_twiddle_sched
  import winv_twiddle_sched_pkg::*;
#(
  parameter int RING_DEPTH = RING_DEPTH_DEF,
  parameter int PE_DEPTH   = PE_DEPTH_DEF,
  parameter int HLEN       = 9,
  parameter int STAGE_GAP  = 0,
  localparam int STW = ($clog2(RING_DEPTH) > 0) ? $clog2(RING_DEPTH) : 1,
  localparam int SW  = (RING_DEPTH - PE_DEPTH - 1 > 0) ? (RING_DEPTH - PE_DEPTH - 1) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic            stall,
  output logic [HLEN-1:0] raddr,
  output logic            tw_valid,
  output logic [STW-1:0]  tw_stage,
  output logic [SW-1:0]   tw_slot,
  output logic            busy,
  output logic            done
);

  localparam logic [SW-1:0]  CNT_LAST = SW'((32'd1 << (RING_DEPTH - PE_DEPTH - 1)) - 32'd1);
  localparam logic [STW-1:0] S_LAST   = STW'(RING_DEPTH - 1);
  localparam logic [3:0]     GAP_LAST = 4'(STAGE_GAP - 1);

  sched_state_e    state_r, state_nxt_s;
  logic [STW-1:0]  s_r, s_nxt_s;
  logic [SW-1:0]   cnt_r, cnt_nxt_s;
  logic [3:0]      gap_r, gap_nxt_s;
  logic [HLEN-1:0] raddr_r, addr_s;
  logic            tw_valid_r, busy_r, done_r;
  logic [STW-1:0]  tw_stage_r;
  logic [SW-1:0]   tw_slot_r;
  logic            issue_s, done_nxt_s;

  // Address follows the next counter values so raddr_r always matches the slot being issued.
  winv_addr_calc #(
    .RING_DEPTH(RING_DEPTH),
    .PE_DEPTH  (PE_DEPTH),
    .HLEN      (HLEN),
    .STW       (STW),
    .SW        (SW)
  ) u_addr (
    .stage(s_nxt_s),
    .cnt  (cnt_nxt_s),
    .raddr(addr_s)
  );

  // Next-state and counter logic; abort has priority, stall freezes every non-idle state.
  always_comb begin
    state_nxt_s = state_r;
    s_nxt_s     = s_r;
    cnt_nxt_s   = cnt_r;
    gap_nxt_s   = gap_r;
    done_nxt_s  = 1'b0;
    issue_s     = 1'b0;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      s_nxt_s     = '0;
      cnt_nxt_s   = '0;
      gap_nxt_s   = '0;
    end else if (stall && (state_r != ST_IDLE)) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = ST_RUN;
            s_nxt_s     = '0;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          issue_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = '0;
            if (s_r == S_LAST) begin
              state_nxt_s = ST_DRAIN;
            end else if (STAGE_GAP > 0) begin
              s_nxt_s     = s_r + STW'(1);
              gap_nxt_s   = '0;
              state_nxt_s = ST_GAP;
            end else begin
              s_nxt_s     = s_r + STW'(1);
              state_nxt_s = ST_RUN;
            end
          end else begin
            cnt_nxt_s = cnt_r + SW'(1);
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_LAST) begin
            gap_nxt_s   = '0;
            state_nxt_s = ST_RUN;
          end else begin
            gap_nxt_s = gap_r + 4'd1;
          end
        end
        ST_DRAIN: begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and output registers; tags lag the issue cycle by one to line up with ROM dout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      s_r        <= '0;
      cnt_r      <= '0;
      gap_r      <= '0;
      raddr_r    <= '0;
      tw_valid_r <= 1'b0;
      tw_stage_r <= '0;
      tw_slot_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      s_r        <= s_nxt_s;
      cnt_r      <= cnt_nxt_s;
      gap_r      <= gap_nxt_s;
      if (state_nxt_s == ST_RUN) begin
        raddr_r <= addr_s;
      end
      tw_valid_r <= issue_s;
      tw_stage_r <= s_r;
      tw_slot_r  <= cnt_r;
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= done_nxt_s;
    end
  end

  assign raddr    = raddr_r;
  assign tw_valid = tw_valid_r;
  assign tw_stage = tw_stage_r;
  assign tw_slot  = tw_slot_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_winv_twiddle_sched.sv
// Scoreboard bench for winv_twiddle_sched: a ROM model (value = address) feeds
// a monitor that pops expected twiddles computed from the stage/slot address rules.
module tb_winv_twiddle_sched;

  localparam int RD  = 10;
  localparam int PD  = 5;
  localparam int HL  = 9;
  localparam int GAP = 3;
  localparam int B   = 1 << (RD - PD - 1);
  localparam int NOM = RD * B + (RD - 1) * GAP + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic [HL-1:0] raddr;
  logic          tw_valid;
  logic [3:0]    tw_stage;
  logic [3:0]    tw_slot;
  logic          busy;
  logic          done;

  logic [HL-1:0] rom [0:(1<<HL)-1];
  logic [HL-1:0] dout;

  typedef struct {
    int stage;
    int slot;
    int addr;
  } tw_t;

  tw_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;

  winv_twiddle_sched #(
    .RING_DEPTH(RD),
    .PE_DEPTH  (PD),
    .HLEN      (HL),
    .STAGE_GAP (GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .stall   (stall),
    .raddr   (raddr),
    .tw_valid(tw_valid),
    .tw_stage(tw_stage),
    .tw_slot (tw_slot),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) dout <= rom[raddr];

  initial begin
    for (int i = 0; i < (1 << HL); i++) rom[i] = HL'(i);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference address: shared twiddle per early stage, then 2^k twiddles spread evenly over B slots.
  function automatic int exp_addr(input int s, input int c);
    int k;
    if (s < PD) return s;
    k = s - PD;
    return PD + (2 ** k) - 1 + c / (2 ** (RD - PD - 1 - k));
  endfunction

  task automatic push_pass();
    tw_t e;
    for (int s = 0; s < RD; s++) begin
      for (int c = 0; c < B; c++) begin
        e.stage = s;
        e.slot  = c;
        e.addr  = exp_addr(s, c);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every live ROM word must be the next expected twiddle with matching tags.
  always @(negedge clk) begin
    tw_t e;
    if (reset_n && tw_valid) begin
      chk("pending_expect", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dout", int'(dout), e.addr);
        chk("tw_stage", int'(tw_stage), e.stage);
        chk("tw_slot", int'(tw_slot), e.slot);
      end
    end
  end

  // One full pass; stall either random or a fixed window (cycle offsets from start).
  task automatic run_pass(input bit rnd, input int st_at, input int st_len, input int hold_addr);
    int c0;
    int nst;
    bit st;
    nst   = 0;
    start = 1'b1;
    c0    = cyc;
    push_pass();
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("first_raddr", int'(raddr), 0);
    for (int i = 0; i < 4 * NOM && !done; i++) begin
      if (rnd) st = ($urandom_range(0, 4) == 0);
      else     st = ((cyc - c0) >= st_at) && ((cyc - c0) < st_at + st_len);
      if (st && busy) nst++;
      if (!rnd && st) chk("stall_hold_raddr", int'(raddr), hold_addr);
      stall = st;
      start = rnd && busy && ($urandom_range(0, 5) == 0);
      tick();
    end
    stall = 1'b0;
    start = 1'b0;
    chk("done_cycle", cyc - c0, NOM + nst);
    chk("done", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("queue_empty", exp_q.size(), 0);
    tick();
    chk("done_pulse", int'(done), 0);
    exp_q.delete();
  endtask

  initial begin
    int c0;
    repeat (3) tick();
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_tw_valid", int'(tw_valid), 0);
    chk("rst_tw_stage", int'(tw_stage), 0);
    chk("rst_tw_slot", int'(tw_slot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Plain pass, then a 4-cycle stall at stage 6 slot 9.
    run_pass(1'b0, -1, 0, 0);
    repeat (3) tick();
    run_pass(1'b0, 1 + 6 * (B + GAP) + 9, 4, exp_addr(6, 9));
    repeat (3) tick();

    // Abort (with a coincident start) in stage 3.
    start = 1'b1;
    c0    = cyc;
    push_pass();
    tick();
    start = 1'b0;
    while ((cyc - c0) < 1 + 3 * (B + GAP) + 2) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_tw_valid", int'(tw_valid), 0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", int'(done), 0);
      chk("abort_idle_valid", int'(tw_valid), 0);
    end
    run_pass(1'b0, -1, 0, 0);
    repeat (3) tick();

    // Asynchronous reset in stage 8, with a start attempt while busy just before.
    start = 1'b1;
    c0    = cyc;
    push_pass();
    tick();
    start = 1'b0;
    while ((cyc - c0) < 1 + 8 * (B + GAP) + 4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_mid_stage8", int'(busy), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_raddr", int'(raddr), 0);
    chk("arst_tw_valid", int'(tw_valid), 0);
    chk("arst_tw_stage", int'(tw_stage), 0);
    chk("arst_tw_slot", int'(tw_slot), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_done", int'(done), 0);
    end

    // Random stalls and ignored starts while busy.
    run_pass(1'b1, 0, 0, 0);
    repeat (2) tick();
    run_pass(1'b1, 0, 0, 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
